dk27_state_driver: RTL and testbench

DK27_STATE_DRIVER -- requirements
Module: dk27_state_driver

---
 rtl/dk27_state_driver.sv | 175 +++++++++++++++++
 tb/tb_dk27_state_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dk27_state_driver.sv
// dk27_state_driver
//
// Sequences one symbol at a time through an external combinational
// next-state network for the 7-state DK27 machine. It presents the current
// state and the input symbol on vec_out, waits for the network to settle,
// captures the network's response from vec_in, then holds the captured
// output bits until the consumer takes them.
//
// Ports
//   clk        single rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input symbol offered
//   in_bit     input symbol value
//   in_ready   driver can accept a symbol this cycle (IDLE only)
//   vec_out    [8:2] current-state one-hot S6..S0, [1:0] symbol one-hot
//   vec_in     [8:2] next-state one-hot, [1:0] output bits from the network
//   out_valid  captured result available
//   out_ready  consumer accepts the result
//   out_bits   captured vec_in[1:0] (00 after a bad capture)
//   state_idx  binary index of the current state (0..6)
//   err        sticky flag: a non-one-hot next state was captured
//   step_cnt   number of successful transitions, wraps at 16 bits
//
// Parameters
//   SETTLE_CYCLES  cycles vec_out is held before vec_in is sampled (1..15)
//   INIT_STATE     state index loaded at reset and on error recovery (0..6)

module dk27_state_driver #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned INIT_STATE    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic [8:0]  vec_out,
    input  logic [8:0]  vec_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_bits,
    output logic [2:0]  state_idx,
    output logic        err,
    output logic [15:0] step_cnt
);

    localparam logic [2:0] INIT_IDX    = 3'(INIT_STATE);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        RESULT
    } ctrl_t;

    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic [2:0] state_q;
    logic       in_bit_q;
    logic [3:0] settle_cnt;

    logic [6:0] next_onehot;
    logic       next_is_onehot;
    logic [2:0] next_idx;

    // Control state register. Reset parks the sequencer in IDLE so any
    // operation in flight is dropped without a capture or a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= IDLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Next-state logic for the sequencer. SETTLE exits once the counter has
    // counted SETTLE_CYCLES cycles (it starts at 0 on the first SETTLE cycle).
    always_comb begin
        ctrl_d = ctrl_q;
        unique case (ctrl_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    ctrl_d = CAPTURE;
                end
            end
            CAPTURE: begin
                ctrl_d = RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    ctrl_d = IDLE;
                end
            end
            default: begin
                ctrl_d = IDLE;
            end
        endcase
    end

    // Handshake outputs and the drive vector toward the network. The symbol
    // one-hot is only presented while the network is being evaluated.
    always_comb begin
        in_ready     = (ctrl_q == IDLE);
        out_valid    = (ctrl_q == RESULT);
        state_idx    = state_q;
        vec_out      = '0;
        vec_out[8:2] = 7'd1 << state_q;
        if ((ctrl_q == SETTLE) || (ctrl_q == CAPTURE)) begin
            vec_out[1:0] = in_bit_q ? 2'b10 : 2'b01;
        end
    end

    // Decode the network's next-state field: exactly-one-bit test via the
    // clear-lowest-set-bit trick, plus a priority encode to a binary index.
    // The encode result only matters when the field is one-hot.
    always_comb begin
        next_onehot    = vec_in[8:2];
        next_is_onehot = (next_onehot != 7'd0) &&
                         ((next_onehot & (next_onehot - 7'd1)) == 7'd0);
        next_idx       = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (next_onehot[i]) begin
                next_idx = 3'(i);
            end
        end
    end

    // Datapath registers. The symbol is latched on accept; the state, output
    // bits, error flag and step counter only change in the single CAPTURE
    // cycle. A bad capture recovers to INIT_STATE and leaves step_cnt alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_IDX;
            in_bit_q   <= 1'b0;
            settle_cnt <= 4'd0;
            out_bits   <= 2'b00;
            err        <= 1'b0;
            step_cnt   <= 16'd0;
        end else begin
            unique case (ctrl_q)
                IDLE: begin
                    if (in_valid) begin
                        in_bit_q   <= in_bit;
                        settle_cnt <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (next_is_onehot) begin
                        state_q  <= next_idx;
                        out_bits <= vec_in[1:0];
                        step_cnt <= step_cnt + 16'd1;
                    end else begin
                        state_q  <= INIT_IDX;
                        out_bits <= 2'b00;
                        err      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dk27_state_driver.sv
// tb_dk27_state_driver
//
// Directed bench for dk27_state_driver. Instance u_a uses the default
// parameters and is checked through a scoreboard: each accepted symbol
// pushes its hand-computed result, and a monitor pops and compares whenever
// u_a completes an out_valid/out_ready handshake. Instance u_b uses
// SETTLE_CYCLES=3 and INIT_STATE=4 for the mid-operation reset scenario.
// Inputs change 2 time units after the rising edge; outputs are read there
// or on the falling edge.

module tb_dk27_state_driver;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 3;

    typedef struct packed {
        logic [1:0]  bits;
        logic [2:0]  idx;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_a, in_valid_a, in_bit_a, in_ready_a, out_valid_a, out_ready_a, err_a;
    logic [8:0]  vec_out_a, vec_in_a;
    logic [1:0]  out_bits_a;
    logic [2:0]  state_idx_a;
    logic [15:0] step_cnt_a;

    logic        rst_b, in_valid_b, in_bit_b, in_ready_b, out_valid_b, out_ready_b, err_b;
    logic [8:0]  vec_out_b, vec_in_b;
    logic [1:0]  out_bits_b;
    logic [2:0]  state_idx_b;
    logic [15:0] step_cnt_b;

    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t popped;

    dk27_state_driver #(.SETTLE_CYCLES(SETTLE_A), .INIT_STATE(0)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_bit(in_bit_a),
        .in_ready(in_ready_a), .vec_out(vec_out_a), .vec_in(vec_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bits(out_bits_a),
        .state_idx(state_idx_a), .err(err_a), .step_cnt(step_cnt_a)
    );

    dk27_state_driver #(.SETTLE_CYCLES(SETTLE_B), .INIT_STATE(4)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_bit(in_bit_b),
        .in_ready(in_ready_b), .vec_out(vec_out_b), .vec_in(vec_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bits(out_bits_b),
        .state_idx(state_idx_b), .err(err_b), .step_cnt(step_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a handshake never arrives.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input logic [1:0] b, input logic [2:0] i,
                                input logic e, input logic [15:0] c);
        exp_t r;
        r.bits = b;
        r.idx  = i;
        r.err  = e;
        r.cnt  = c;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer one symbol to u_a once it is ready, queue its expected result,
    // check the settle drive vector, then wait for out_valid and check the
    // accept-to-result latency. exp_wait >= 0 also checks the idle wait.
    task automatic applyStimulus(input logic b, input logic [8:0] resp,
                                 input logic [8:0] settle_vec, input exp_t e,
                                 input int exp_wait);
        int n;
        n = 0;
        while (!in_ready_a && n < 40) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready_a), 32'd1);
        if (exp_wait >= 0) begin
            checkOutput("accept_wait", 32'(n), 32'(exp_wait));
        end
        in_valid_a = 1'b1;
        in_bit_a   = b;
        vec_in_a   = resp;
        sb.push_back(e);
        tick();
        in_valid_a = 1'b0;
        checkOutput("settle_vec_out", 32'(vec_out_a), 32'(settle_vec));
        checkOutput("busy_in_ready", 32'(in_ready_a), 32'd0);
        n = 0;
        while (!out_valid_a && n < 40) begin
            tick();
            n++;
        end
        checkOutput("result_latency", 32'(n), 32'(SETTLE_A + 1));
    endtask

    // Scoreboard monitor: compare every completed result of u_a.
    always @(negedge clk) begin
        if (!rst_a && out_valid_a && out_ready_a) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got out_bits=0x%0h required no result", out_bits_a);
            end else begin
                popped = sb.pop_front();
                checkOutput("sb_out_bits", 32'(out_bits_a), 32'(popped.bits));
                checkOutput("sb_state_idx", 32'(state_idx_a), 32'(popped.idx));
                checkOutput("sb_err", 32'(err_a), 32'(popped.err));
                checkOutput("sb_step_cnt", 32'(step_cnt_a), 32'(popped.cnt));
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_a = 1'b1; in_valid_a = 1'b0; in_bit_a = 1'b0; vec_in_a = '0; out_ready_a = 1'b1;
        rst_b = 1'b1; in_valid_b = 1'b0; in_bit_b = 1'b0; vec_in_b = '0; out_ready_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Reset state of both instances.
        checkOutput("rst_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("rst_vec_out", 32'(vec_out_a), 32'(9'b000000100));
        checkOutput("rst_state_idx", 32'(state_idx_a), 32'd0);
        checkOutput("rst_step_cnt", 32'(step_cnt_a), 32'd0);
        checkOutput("rst_err", 32'(err_a), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_out_bits", 32'(out_bits_a), 32'd0);
        checkOutput("rst_b_vec_out", 32'(vec_out_b), 32'(9'b001000000));
        checkOutput("rst_b_state_idx", 32'(state_idx_b), 32'd4);

        // Normal steps, back to back with out_ready high.
        applyStimulus(1'b1, 9'b000010001, 9'b000000110, mk(2'b01, 3'd2, 1'b0, 16'd1), 0);
        applyStimulus(1'b0, {7'b1000000, 2'b10}, 9'b000010001, mk(2'b10, 3'd6, 1'b0, 16'd2), 1);
        // Two-hot and zero next-state fields: error recovery to state 0.
        applyStimulus(1'b1, {7'b0000110, 2'b11}, 9'b100000010, mk(2'b00, 3'd0, 1'b1, 16'd2), 1);
        applyStimulus(1'b0, {7'b0000000, 2'b01}, 9'b000000101, mk(2'b00, 3'd0, 1'b1, 16'd2), 1);
        // A good step after an error still counts; err stays set.
        applyStimulus(1'b1, {7'b0001000, 2'b11}, 9'b000000110, mk(2'b11, 3'd3, 1'b1, 16'd3), 1);
        tick();

        // Consumer stall: result must hold and new symbols are dropped.
        out_ready_a = 1'b0;
        applyStimulus(1'b0, {7'b0100000, 2'b01}, 9'b000100001, mk(2'b01, 3'd5, 1'b1, 16'd4), 0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_out_valid", 32'(out_valid_a), 32'd1);
            checkOutput("stall_out_bits", 32'(out_bits_a), 32'(2'b01));
            checkOutput("stall_in_ready", 32'(in_ready_a), 32'd0);
            in_valid_a = (k % 2 == 0);
            in_bit_a   = 1'b1;
            tick();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        tick();
        tick();
        checkOutput("post_stall_idle", 32'(in_ready_a), 32'd1);
        checkOutput("post_stall_no_result", 32'(out_valid_a), 32'd0);
        checkOutput("post_stall_step_cnt", 32'(step_cnt_a), 32'd4);
        checkOutput("post_stall_vec_out", 32'(vec_out_a), 32'(9'b010000000));

        // Counter wrap from 0xFFFF.
        force u_a.step_cnt = 16'hFFFF;
        tick();
        release u_a.step_cnt;
        tick();
        checkOutput("preload_step_cnt", 32'(step_cnt_a), 32'h0000FFFF);
        applyStimulus(1'b1, {7'b0000001, 2'b00}, 9'b010000010, mk(2'b00, 3'd0, 1'b1, 16'h0000), 0);
        applyStimulus(1'b0, {7'b0010000, 2'b10}, 9'b000000101, mk(2'b10, 3'd4, 1'b1, 16'h0001), 1);
        tick();

        // u_b: reset during the second SETTLE cycle aborts the operation.
        in_valid_b = 1'b1;
        in_bit_b   = 1'b0;
        vec_in_b   = {7'b0000001, 2'b11};
        tick();
        in_valid_b = 1'b0;
        checkOutput("b_settle_vec_out", 32'(vec_out_b), 32'(9'b001000001));
        tick();
        rst_b = 1'b1;
        #1;
        checkOutput("b_abort_in_ready", 32'(in_ready_b), 32'd1);
        checkOutput("b_abort_vec_out", 32'(vec_out_b), 32'(9'b001000000));
        checkOutput("b_abort_state_idx", 32'(state_idx_b), 32'd4);
        checkOutput("b_abort_out_bits", 32'(out_bits_b), 32'd0);
        checkOutput("b_abort_step_cnt", 32'(step_cnt_b), 32'd0);
        checkOutput("b_abort_err", 32'(err_b), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("b_abort_no_valid", 32'(out_valid_b), 32'd0);
        end
        rst_b      = 1'b0;
        in_valid_b = 1'b1;
        in_bit_b   = 1'b1;
        tick();
        in_valid_b = 1'b0;
        checkOutput("b_first_accept", 32'(in_ready_b), 32'd0);
        checkOutput("b_accept_vec_out", 32'(vec_out_b), 32'(9'b001000010));
        n = 0;
        while (!out_valid_b && n < 40) begin
            tick();
            n++;
        end
        checkOutput("b_latency", 32'(n), 32'(SETTLE_B + 1));
        checkOutput("b_out_bits", 32'(out_bits_b), 32'(2'b11));
        checkOutput("b_state_idx", 32'(state_idx_b), 32'd0);
        checkOutput("b_step_cnt", 32'(step_cnt_b), 32'd1);
        tick();
        checkOutput("b_done_idle", 32'(in_ready_b), 32'd1);

        tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
